// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions: MIPS opcode constants, stall state encoding
// and small decode helpers used by the hazard and forwarding logic.
package hazard_stall_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } stall_state_e;

  // rt is a true source only for R-type, stores and the two compare branches
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return op == OP_LW;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_wreg_sel.sv
// Destination-register extraction for one pipeline stage; register 0 is
// reported as invalid so it can never create a dependency.
module wreg_sel
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] instru,
  output logic [4:0]  wreg,
  output logic        wreg_valid
);

  logic unused_bits;

  assign wreg        = (instru[31:26] == OP_R) ? instru[15:11] : instru[20:16];
  assign wreg_valid  = (wreg != 5'd0);
  assign unused_bits = ^{instru[25:21], instru[10:0]};

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection: computes the stall depth for load-use and
// branch-compare dependencies, sequences multi-cycle stalls and flushes.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instru,
  input  logic [31:0] ex_instru,
  input  logic [31:0] ex_mem_instru,
  input  logic        c_ex_MemRead,
  input  logic        c_ex_RegWrite,
  input  logic        c_ex_mem_MemRead,
  input  logic        c_ex_mem_RegWrite,
  input  logic        c_id_branch,
  input  logic        c_id_jump,
  input  logic        c_branch_taken,
  output logic        c_pc_write,
  output logic        c_if_id_write,
  output logic        c_id_ex_bubble,
  output logic        c_if_id_flush,
  output logic [15:0] c_stall_cnt
);

  logic [4:0]             ex_wreg;
  logic [4:0]             mem_wreg;
  logic                   ex_wreg_vld;
  logic                   mem_wreg_vld;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_rt_used;
  logic                   ex_match;
  logic                   mem_match;
  logic [CNT_W-1:0]       need;
  logic [CNT_W-1:0]       cnt;
  stall_state_e           state;
  logic                   stall;
  logic                   unused_id;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] max_need(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  wreg_sel u_ex_wreg (
    .instru     (ex_instru),
    .wreg       (ex_wreg),
    .wreg_valid (ex_wreg_vld)
  );

  wreg_sel u_mem_wreg (
    .instru     (ex_mem_instru),
    .wreg       (mem_wreg),
    .wreg_valid (mem_wreg_vld)
  );

  assign id_rs      = id_instru[25:21];
  assign id_rt      = id_instru[20:16];
  assign id_rt_used = uses_rt(id_instru[31:26]);
  assign unused_id  = ^id_instru[15:0];

  assign ex_match  = ex_wreg_vld &&
                     ((ex_wreg == id_rs) || (id_rt_used && (ex_wreg == id_rt)));
  assign mem_match = mem_wreg_vld &&
                     ((mem_wreg == id_rs) || (id_rt_used && (mem_wreg == id_rt)));

  // Stall depth is the worst case over all hazard rules that fire
  always_comb begin
    need = '0;
    if (c_ex_MemRead && ex_match)
      need = max_need(need, 2'd1);
    if (c_id_branch && c_ex_RegWrite && !c_ex_MemRead && ex_match)
      need = max_need(need, 2'd1);
    if (c_id_branch && c_ex_MemRead && ex_match)
      need = max_need(need, 2'd2);
    if (c_id_branch && c_ex_mem_MemRead && c_ex_mem_RegWrite && mem_match)
      need = max_need(need, 2'd1);
  end

  assign state = (cnt == '0) ? ST_RUN : ST_HOLD;

  // Reset forces run values on the outputs without waiting for an edge
  assign stall = !reset && ((state == ST_HOLD) || (need != '0));

  assign c_pc_write     = !stall;
  assign c_if_id_write  = !stall;
  assign c_id_ex_bubble = stall;
  assign c_if_id_flush  = !reset && !stall &&
                          ((c_branch_taken && c_id_branch) || c_id_jump);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      c_stall_cnt <= '0;
    end else begin
      case (state)
        ST_RUN:  if (need != '0) cnt <= need - 2'd1;
        ST_HOLD: cnt <= cnt - 2'd1;
        default: cnt <= '0;
      endcase
      if (stall)
        c_stall_cnt <= sat_inc(c_stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scenario bench for hazard_stall_ctrl with a queue-based scoreboard.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] id_instru;
  logic [31:0] ex_instru;
  logic [31:0] ex_mem_instru;
  logic        c_ex_MemRead;
  logic        c_ex_RegWrite;
  logic        c_ex_mem_MemRead;
  logic        c_ex_mem_RegWrite;
  logic        c_id_branch;
  logic        c_id_jump;
  logic        c_branch_taken;
  logic        c_pc_write;
  logic        c_if_id_write;
  logic        c_id_ex_bubble;
  logic        c_if_id_flush;
  logic [15:0] c_stall_cnt;

  localparam logic [6:0] MR  = 7'b1000000;
  localparam logic [6:0] RW  = 7'b0100000;
  localparam logic [6:0] MMR = 7'b0010000;
  localparam logic [6:0] MRW = 7'b0001000;
  localparam logic [6:0] BR  = 7'b0000100;
  localparam logic [6:0] JP  = 7'b0000010;
  localparam logic [6:0] TK  = 7'b0000001;

  localparam logic [31:0] LW2   = 32'h8C220000;
  localparam logic [31:0] LW0   = 32'h8C200000;
  localparam logic [31:0] ADD3  = 32'h00441820;
  localparam logic [31:0] ADD2  = 32'h00A41020;
  localparam logic [31:0] ADDZ  = 32'h00001820;
  localparam logic [31:0] BEQ25 = 32'h10450003;
  localparam logic [31:0] BEQ20 = 32'h10400003;
  localparam logic [31:0] JMP   = 32'h08000010;
  localparam logic [31:0] LW4   = 32'h8C640000;
  localparam logic [31:0] LW_4  = 32'h8C240000;

  typedef struct packed {
    logic        pc_write;
    logic        if_id_write;
    logic        bubble;
    logic        flush;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  hazard_stall_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .id_instru         (id_instru),
    .ex_instru         (ex_instru),
    .ex_mem_instru     (ex_mem_instru),
    .c_ex_MemRead      (c_ex_MemRead),
    .c_ex_RegWrite     (c_ex_RegWrite),
    .c_ex_mem_MemRead  (c_ex_mem_MemRead),
    .c_ex_mem_RegWrite (c_ex_mem_RegWrite),
    .c_id_branch       (c_id_branch),
    .c_id_jump         (c_id_jump),
    .c_branch_taken    (c_branch_taken),
    .c_pc_write        (c_pc_write),
    .c_if_id_write     (c_if_id_write),
    .c_id_ex_bubble    (c_id_ex_bubble),
    .c_if_id_flush     (c_if_id_flush),
    .c_stall_cnt       (c_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [31:0] id, input logic [31:0] ex,
                       input logic [31:0] exm, input logic [6:0] ctl);
    id_instru     = id;
    ex_instru     = ex;
    ex_mem_instru = exm;
    {c_ex_MemRead, c_ex_RegWrite, c_ex_mem_MemRead, c_ex_mem_RegWrite,
     c_id_branch, c_id_jump, c_branch_taken} = ctl;
  endtask

  // Called one time unit after a rising edge; leaves off at the same phase.
  task automatic do_reset();
    drive(32'h0, 32'h0, 32'h0, 7'h0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // One pipeline cycle: drive, push expectation, compare at the falling edge.
  task automatic cyc(input string name, input logic [31:0] id, input logic [31:0] ex,
                     input logic [31:0] exm, input logic [6:0] ctl,
                     input logic stall, input logic flush, input logic [15:0] cnt_exp);
    exp_t e;
    drive(id, ex, exm, ctl);
    e.pc_write    = !stall;
    e.if_id_write = !stall;
    e.bubble      = stall;
    e.flush       = flush;
    e.cnt         = cnt_exp;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (c_pc_write !== e.pc_write) begin
      bad++;
      $display("FAIL %s pc_write got=%b want=%b", name, c_pc_write, e.pc_write);
    end
    total++;
    if (c_if_id_write !== e.if_id_write) begin
      bad++;
      $display("FAIL %s if_id_write got=%b want=%b", name, c_if_id_write, e.if_id_write);
    end
    total++;
    if (c_id_ex_bubble !== e.bubble) begin
      bad++;
      $display("FAIL %s bubble got=%b want=%b", name, c_id_ex_bubble, e.bubble);
    end
    total++;
    if (c_if_id_flush !== e.flush) begin
      bad++;
      $display("FAIL %s flush got=%b want=%b", name, c_if_id_flush, e.flush);
    end
    total++;
    if (c_stall_cnt !== e.cnt) begin
      bad++;
      $display("FAIL %s stall_cnt got=%0d want=%0d", name, c_stall_cnt, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(ADD3, LW2, 32'h0, MR | RW | JP);
    #1;
    total++;
    if ({c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=1100",
               {c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush});
    end
    @(posedge clk);
    #1;
    total++;
    if (c_stall_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_stall_cnt got=%0d want=0", c_stall_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    cyc("lu_stall", ADD3, LW2, 32'h0, MR | RW, 1'b1, 1'b0, 16'd0);
    cyc("lu_after", ADD3, 32'h0, LW2, MMR | MRW, 1'b0, 1'b0, 16'd1);
    cyc("lu_idle", 32'h0, 32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 16'd1);
    // lw writes rt, ID lw only reads rs: rt match is not a hazard
    cyc("lu_rt_unused", LW4, LW_4, 32'h0, MR | RW, 1'b0, 1'b0, 16'd1);
  endtask

  task automatic test_branch_alu();
    do_reset();
    cyc("bralu_stall", BEQ25, ADD2, 32'h0, RW | BR | TK, 1'b1, 1'b0, 16'd0);
    cyc("bralu_flush", BEQ25, 32'h0, ADD2, MRW | BR | TK, 1'b0, 1'b1, 16'd1);
    cyc("bralu_idle", 32'h0, 32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 16'd1);
  endtask

  task automatic test_branch_load();
    do_reset();
    cyc("brld_c0", BEQ20, LW2, 32'h0, MR | RW | BR | TK, 1'b1, 1'b0, 16'd0);
    cyc("brld_c1", BEQ20, 32'h0, LW2, MMR | MRW | BR | TK, 1'b1, 1'b0, 16'd1);
    cyc("brld_flush", BEQ20, 32'h0, 32'h0, BR | TK, 1'b0, 1'b1, 16'd2);
    cyc("brld_idle", 32'h0, 32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 16'd2);
  endtask

  task automatic test_zero_reg_and_jump();
    do_reset();
    cyc("zero_no_stall", ADDZ, LW0, 32'h0, MR | RW, 1'b0, 1'b0, 16'd0);
    cyc("jump_flush", JMP, 32'h0, 32'h0, JP, 1'b0, 1'b1, 16'd0);
    cyc("not_taken", BEQ25, 32'h0, 32'h0, BR, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    cyc("rh_c0", BEQ20, LW2, 32'h0, MR | RW | BR | TK, 1'b1, 1'b0, 16'd0);
    drive(BEQ20, 32'h0, LW2, MMR | MRW | BR | TK);
    #1;
    total++;
    if (c_pc_write !== 1'b0) begin
      bad++;
      $display("FAIL rh_hold_stall pc_write got=%b want=0", c_pc_write);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush} !== 4'b1100) begin
      bad++;
      $display("FAIL rh_reset_outputs got=%b want=1100",
               {c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush});
    end
    total++;
    if (c_stall_cnt !== 16'h0) begin
      bad++;
      $display("FAIL rh_stall_cnt got=%0d want=0", c_stall_cnt);
    end
    drive(32'h0, 32'h0, 32'h0, 7'h0);
    reset = 1'b0;
    #1;
    total++;
    if (c_pc_write !== 1'b1) begin
      bad++;
      $display("FAIL rh_run_after pc_write got=%b want=1", c_pc_write);
    end
    cyc("rh_post_edge", 32'h0, 32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 16'd0);
    cyc("rh_post_edge2", 32'h0, 32'h0, 32'h0, 7'h0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_saturation();
    do_reset();
    drive(ADD3, LW2, 32'h0, MR | RW);
    repeat (65534) @(posedge clk);
    #1;
    total++;
    if (c_stall_cnt !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_pre got=%h want=fffe", c_stall_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (c_stall_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_hold got=%h want=ffff", c_stall_cnt);
    end
    total++;
    if (c_id_ex_bubble !== 1'b1) begin
      bad++;
      $display("FAIL sat_still_stalling bubble got=%b want=1", c_id_ex_bubble);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(32'h0, 32'h0, 32'h0, 7'h0);
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_zero_reg_and_jump();
    test_reset_mid_hold();
    test_saturation();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
